// File: rtl/mutual_pkg.sv
// rtl/mutual_pkg.sv - shared types and constants for the mutual-exclusion rule scheduler
package mutual_pkg;

  localparam int N_DEFAULT = 3;
  localparam int IDX_W_DEFAULT = (N_DEFAULT > 1) ? $clog2(N_DEFAULT) : 1;

  typedef logic [IDX_W_DEFAULT-1:0] rule_idx_t;

  // Node state encoding shared with the system block and its checkers
  localparam logic [1:0] NODE_I = 2'd0;
  localparam logic [1:0] NODE_T = 2'd1;
  localparam logic [1:0] NODE_C = 2'd2;
  localparam logic [1:0] NODE_E = 2'd3;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotate-priority pick of the first set bit at or after ptr
module rr_pick #(
  parameter int N = 3,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;

  // Walk offsets from the far end back to ptr so the nearest set bit is written last and wins
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    sum   = '0;
    cand  = '0;
    for (int off = N - 1; off >= 0; off--) begin
      sum = {1'b0, ptr} + (IDX_W + 1)'(off);
      if (sum >= (IDX_W + 1)'(N)) begin
        sum = sum - (IDX_W + 1)'(N);
      end
      cand = sum[IDX_W-1:0];
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mutual_rule_scheduler.sv
// rtl/mutual_rule_scheduler.sv - round-robin rule-enable scheduler with force, stall and starvation tracking
module mutual_rule_scheduler
  import mutual_pkg::*;
#(
  parameter int N        = N_DEFAULT,
  parameter int MAX_WAIT = 8,
  parameter int CNT_W    = 16,
  localparam int IDX_W   = (N > 1) ? $clog2(N) : 1,
  localparam int WAIT_W  = $clog2(MAX_WAIT + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N-1:0]     io_guard_ok,
  input  logic             io_stall,
  input  logic             io_force_valid,
  input  logic [IDX_W-1:0] io_force_idx,
  output logic [N-1:0]     io_en_a,
  output logic             io_starved,
  output logic [N-1:0]     io_starved_vec,
  output logic [CNT_W-1:0] io_fire_cnt
);

  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  ptr_next;
  logic [N-1:0]      en_next;
  logic              pick_valid;
  logic [IDX_W-1:0]  pick_idx;
  logic [WAIT_W-1:0] wait_cnt [N];

  rr_pick #(.N(N)) u_pick (
    .req   (io_guard_ok),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Grant decision: force beats stall beats round-robin; only a round-robin grant moves ptr
  always_comb begin
    en_next  = '0;
    ptr_next = ptr;
    if (io_force_valid) begin
      if (int'(io_force_idx) < N) begin
        en_next[io_force_idx] = 1'b1;
      end
    end else if (!io_stall && pick_valid) begin
      en_next[pick_idx] = 1'b1;
      ptr_next = (pick_idx == IDX_W'(N - 1)) ? '0 : pick_idx + 1'b1;
    end
  end

  // Registered enable, pointer and fired-cycle counter
  always_ff @(posedge clock) begin
    if (reset) begin
      io_en_a     <= '0;
      ptr         <= '0;
      io_fire_cnt <= '0;
    end else begin
      io_en_a <= en_next;
      ptr     <= ptr_next;
      if (|en_next) begin
        io_fire_cnt <= io_fire_cnt + 1'b1;
      end
    end
  end

  // Per-rule wait counters: clear on grant or false guard, otherwise count up and saturate
  always_ff @(posedge clock) begin
    for (int i = 0; i < N; i++) begin
      if (reset || en_next[i] || !io_guard_ok[i]) begin
        wait_cnt[i] <= '0;
      end else if (wait_cnt[i] != WAIT_W'(MAX_WAIT)) begin
        wait_cnt[i] <= wait_cnt[i] + 1'b1;
      end
    end
  end

  // Starvation flags read straight off the counters, so they drop as soon as a counter clears
  always_comb begin
    io_starved_vec = '0;
    for (int i = 0; i < N; i++) begin
      io_starved_vec[i] = (wait_cnt[i] == WAIT_W'(MAX_WAIT));
    end
    io_starved = |io_starved_vec;
  end

endmodule

// File: tb/tb_mutual_rule_scheduler.sv
// tb/tb_mutual_rule_scheduler.sv - self-checking bench for mutual_rule_scheduler
module tb_mutual_rule_scheduler;

  localparam int N        = 3;
  localparam int MAX_WAIT = 4;
  localparam int CNT_W    = 5;

  logic             clock = 1'b0;
  logic             reset;
  logic [N-1:0]     guard_ok;
  logic             stall;
  logic             force_valid;
  logic [1:0]       force_idx;
  logic [N-1:0]     en_a;
  logic             starved;
  logic [N-1:0]     starved_vec;
  logic [CNT_W-1:0] fire_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  bit m_valid = 1'b0;
  int m_ptr;
  int m_en;
  int m_fire;
  int m_wait [N];

  mutual_rule_scheduler #(.N(N), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clock          (clock),
    .reset          (reset),
    .io_guard_ok    (guard_ok),
    .io_stall       (stall),
    .io_force_valid (force_valid),
    .io_force_idx   (force_idx),
    .io_en_a        (en_a),
    .io_starved     (starved),
    .io_starved_vec (starved_vec),
    .io_fire_cnt    (fire_cnt)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the scheduling rules stated directly, one step per rising edge
  always @(posedge clock) begin
    int g;
    int j;
    bit found;
    if (reset) begin
      m_valid = 1'b1;
      m_ptr   = 0;
      m_en    = 0;
      m_fire  = 0;
      for (int i = 0; i < N; i++) m_wait[i] = 0;
    end else if (m_valid) begin
      g = -1;
      if (force_valid) begin
        if (int'(force_idx) < N) g = int'(force_idx);
      end else if (!stall) begin
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
          j = (m_ptr + k) % N;
          if (!found && guard_ok[j]) begin
            found = 1'b1;
            g = j;
          end
        end
        if (found) m_ptr = (g + 1) % N;
      end
      m_en = (g < 0) ? 0 : (1 << g);
      for (int i = 0; i < N; i++) begin
        if (g == i || !guard_ok[i]) m_wait[i] = 0;
        else if (m_wait[i] < MAX_WAIT) m_wait[i] = m_wait[i] + 1;
      end
      if (g >= 0) m_fire = (m_fire + 1) % (1 << CNT_W);
    end
  end

  // Compare DUT against model on every falling edge once reset has been seen
  always @(negedge clock) begin
    int sv;
    if (m_valid) begin
      sv = 0;
      for (int i = 0; i < N; i++) if (m_wait[i] == MAX_WAIT) sv |= (1 << i);
      check("model_en_a", int'(en_a), m_en);
      check("model_starved_vec", int'(starved_vec), sv);
      check("model_starved", int'(starved), int'(sv != 0));
      check("model_fire_cnt", int'(fire_cnt), m_fire);
    end
  end

  task automatic cyc(input logic r, input logic [N-1:0] g, input logic s,
                     input logic fv, input logic [1:0] fi);
    reset       = r;
    guard_ok    = g;
    stall       = s;
    force_valid = fv;
    force_idx   = fi;
    @(posedge clock);
    #2;
  endtask

  initial begin
    reset = 1'b1; guard_ok = '0; stall = 1'b0; force_valid = 1'b0; force_idx = '0;

    // reset state
    cyc(1, 3'b000, 0, 0, 0);
    cyc(1, 3'b000, 0, 0, 0);
    check("rst_en_a", int'(en_a), 0);
    check("rst_fire", int'(fire_cnt), 0);
    check("rst_starved", int'(starved), 0);

    // all guards true: rotate 001,010,100,001
    cyc(0, 3'b111, 0, 0, 0); check("rr1_en", int'(en_a), 1);
    cyc(0, 3'b111, 0, 0, 0); check("rr2_en", int'(en_a), 2);
    cyc(0, 3'b111, 0, 0, 0); check("rr3_en", int'(en_a), 4);
    cyc(0, 3'b111, 0, 0, 0); check("rr4_en", int'(en_a), 1);
    check("rr4_fire", int'(fire_cnt), 4);

    // reset mid-stream while 010 is showing
    cyc(0, 3'b111, 0, 0, 0); check("mid_en", int'(en_a), 2);
    cyc(1, 3'b111, 0, 0, 0);
    check("mid_rst_en", int'(en_a), 0);
    check("mid_rst_fire", int'(fire_cnt), 0);
    cyc(0, 3'b111, 0, 0, 0); check("mid_first_en", int'(en_a), 1);

    // single guard held
    for (int k = 0; k < 3; k++) begin
      cyc(0, 3'b010, 0, 0, 0);
      check("single_en", int'(en_a), 2);
      check("single_starved", int'(starved), 0);
    end
    check("single_fire", int'(fire_cnt), 4);

    // force replay leaves ptr at 0
    cyc(1, 3'b000, 0, 0, 0);
    cyc(0, 3'b000, 0, 1, 2'd1); check("force1_en", int'(en_a), 2);
    cyc(0, 3'b000, 0, 1, 2'd0); check("force0_en", int'(en_a), 1);
    cyc(0, 3'b111, 0, 0, 0);    check("force_rr_en", int'(en_a), 1);
    check("force_fire", int'(fire_cnt), 3);

    // starvation under stall
    cyc(1, 3'b000, 0, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      cyc(0, 3'b001, 1, 0, 0);
      check("stall_en", int'(en_a), 0);
      check("stall_starved", int'(starved), int'(k >= MAX_WAIT));
    end
    check("stall_vec", int'(starved_vec), 1);
    cyc(0, 3'b001, 0, 0, 0);
    check("unstall_en", int'(en_a), 1);
    check("unstall_starved", int'(starved), 0);

    // force beats stall; out-of-range index grants nothing
    cyc(0, 3'b000, 1, 1, 2'd2); check("force_stall_en", int'(en_a), 4);
    cyc(0, 3'b000, 1, 1, 2'd3); check("force_oor_en", int'(en_a), 0);

    // randomised traffic, model-checked every cycle
    for (int k = 0; k < 300; k++) begin
      cyc(($urandom_range(0, 39) == 0), 3'($urandom), ($urandom_range(0, 5) == 0),
          ($urandom_range(0, 7) == 0), 2'($urandom));
    end
    // heavy stall phase to drive counters into saturation
    for (int k = 0; k < 200; k++) begin
      cyc(($urandom_range(0, 79) == 0), 3'($urandom_range(1, 7)), ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 15) == 0), 2'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
